// File: rtl/mem_write_ctrl.sv
// CPU write-path controller: GPIO writes go out as a registered one-cycle strobe,
// SDRAM writes are posted into a small FIFO and drained over a req/ack handshake.
module mem_write_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_stall,
    output logic                  we_gpio,
    output logic [DATA_WIDTH-1:0] wr_data_gpio,
    output logic                  sdram_wr_req,
    output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
    output logic [DATA_WIDTH-1:0] sdram_wr_data,
    input  logic                  sdram_wr_ack,
    output logic                  wr_pending
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    typedef enum logic {StIdle, StReq} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q, count_d;

    logic gpio_hit, sdram_hit, fifo_full, fifo_empty, push, pop;

    assign gpio_hit   = wr_address[ADDR_WIDTH-1];
    assign sdram_hit  = ~gpio_hit;
    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);

    // No bypass: a full FIFO stalls even if the head pops this cycle.
    assign wr_stall = wr_en & sdram_hit & fifo_full;
    assign push     = wr_en & sdram_hit & ~fifo_full;
    assign pop      = (state_q == StReq) & sdram_wr_ack;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // Next state looks at the post-edge count so a fresh push raises req one cycle later
    // and a push coinciding with the last pop keeps req high.
    always_comb begin
        state_d      = state_q;
        sdram_wr_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_d != '0) state_d = StReq;
            end
            StReq: begin
                sdram_wr_req = 1'b1;
                if (pop && count_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            we_gpio      <= 1'b0;
            wr_data_gpio <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            we_gpio      <= wr_en & gpio_hit;
            wr_data_gpio <= (wr_en & gpio_hit) ? wr_data : '0;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wr_address;
            data_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Storage is not reset, so gate the head to keep outputs defined when empty.
    assign sdram_wr_addr = fifo_empty ? '0 : addr_mem[rd_ptr_q];
    assign sdram_wr_data = fifo_empty ? '0 : data_mem[rd_ptr_q];
    assign wr_pending    = ~fifo_empty | sdram_wr_req;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl: GPIO strobe, posted SDRAM writes, stall, drain, reset.
module tb_mem_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic        wr_stall;
    logic        we_gpio;
    logic [31:0] wr_data_gpio;
    logic        sdram_wr_req;
    logic [31:0] sdram_wr_addr;
    logic [31:0] sdram_wr_data;
    logic        sdram_wr_ack;
    logic        wr_pending;

    int tests  = 0;
    int failed = 0;

    mem_write_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .wr_stall     (wr_stall),
        .we_gpio      (we_gpio),
        .wr_data_gpio (wr_data_gpio),
        .sdram_wr_req (sdram_wr_req),
        .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_data(sdram_wr_data),
        .sdram_wr_ack (sdram_wr_ack),
        .wr_pending   (wr_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic en, input logic [31:0] a, input logic [31:0] d);
        wr_en      = en;
        wr_address = a;
        wr_data    = d;
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_address = '0; wr_data = '0; sdram_wr_ack = 1'b0;
        tick();
        tick();
        chk("rst_we_gpio", 64'(we_gpio), 64'd0);
        chk("rst_gpio_data", 64'(wr_data_gpio), 64'd0);
        chk("rst_req", 64'(sdram_wr_req), 64'd0);
        chk("rst_pending", 64'(wr_pending), 64'd0);
        chk("rst_stall", 64'(wr_stall), 64'd0);
        chk("rst_head_addr", 64'(sdram_wr_addr), 64'd0);
        rst = 1'b0;
        tick();

        // GPIO write
        set_wr(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        chk("gpio_stall", 64'(wr_stall), 64'd0);
        tick();
        chk("gpio_we", 64'(we_gpio), 64'd1);
        chk("gpio_data", 64'(wr_data_gpio), 64'hDEAD_BEEF);
        chk("gpio_req", 64'(sdram_wr_req), 64'd0);
        set_wr(1'b0, 32'h0, 32'h0);
        tick();
        chk("gpio_we_drop", 64'(we_gpio), 64'd0);
        chk("gpio_data_clr", 64'(wr_data_gpio), 64'd0);
        chk("gpio_req2", 64'(sdram_wr_req), 64'd0);

        // Single SDRAM write, ack a few cycles later
        set_wr(1'b1, 32'h0000_0100, 32'h1234_5678);
        tick();
        set_wr(1'b0, 32'h0, 32'h0);
        chk("single_req", 64'(sdram_wr_req), 64'd1);
        chk("single_addr", 64'(sdram_wr_addr), 64'h100);
        chk("single_data", 64'(sdram_wr_data), 64'h1234_5678);
        chk("single_pend", 64'(wr_pending), 64'd1);
        tick();
        chk("single_req_hold", 64'(sdram_wr_req), 64'd1);
        chk("single_addr_hold", 64'(sdram_wr_addr), 64'h100);
        tick();
        chk("single_data_hold", 64'(sdram_wr_data), 64'h1234_5678);
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        chk("single_req_done", 64'(sdram_wr_req), 64'd0);
        chk("single_pend_done", 64'(wr_pending), 64'd0);

        // Fill and stall
        for (int i = 1; i <= 4; i++) begin
            set_wr(1'b1, 32'(i * 4), 32'(i));
            chk("fill_stall", 64'(wr_stall), 64'd0);
            tick();
        end
        set_wr(1'b1, 32'd20, 32'd5);
        chk("full_stall", 64'(wr_stall), 64'd1);
        chk("full_head", 64'(sdram_wr_data), 64'd1);
        tick();
        chk("full_stall_hold", 64'(wr_stall), 64'd1);
        chk("full_req", 64'(sdram_wr_req), 64'd1);
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        #1;
        chk("stall_release", 64'(wr_stall), 64'd0);
        chk("head_after_pop", 64'(sdram_wr_data), 64'd2);
        tick();
        set_wr(1'b0, 32'h0, 32'h0);
        chk("refull_stall", 64'(wr_stall), 64'd0);
        for (int d = 2; d <= 5; d++) begin
            chk("drain_req", 64'(sdram_wr_req), 64'd1);
            chk("drain_data", 64'(sdram_wr_data), 64'(d));
            chk("drain_addr", 64'(sdram_wr_addr), 64'(d * 4));
            sdram_wr_ack = 1'b1;
            tick();
        end
        sdram_wr_ack = 1'b0;
        chk("drain_idle", 64'(sdram_wr_req), 64'd0);
        chk("drain_pend", 64'(wr_pending), 64'd0);

        // GPIO while full
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 32'h40 + 32'(i), 32'h10 + 32'(i));
            tick();
        end
        set_wr(1'b1, 32'h8000_0000, 32'hA5A5_A5A5);
        chk("gpio_full_stall", 64'(wr_stall), 64'd0);
        tick();
        set_wr(1'b0, 32'h0, 32'h0);
        chk("gpio_full_we", 64'(we_gpio), 64'd1);
        chk("gpio_full_data", 64'(wr_data_gpio), 64'hA5A5_A5A5);
        chk("gpio_full_head", 64'(sdram_wr_data), 64'h10);
        for (int i = 0; i < 4; i++) begin
            chk("gpio_full_req", 64'(sdram_wr_req), 64'd1);
            chk("gpio_full_drain", 64'(sdram_wr_data), 64'h10 + 64'(i));
            sdram_wr_ack = 1'b1;
            tick();
        end
        sdram_wr_ack = 1'b0;
        chk("gpio_full_idle", 64'(sdram_wr_req), 64'd0);

        // Continuous ack throughput
        sdram_wr_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 32'h200 + 32'(i), 32'h100 + 32'(i));
            chk("cont_stall", 64'(wr_stall), 64'd0);
            if (i > 0) begin
                chk("cont_req", 64'(sdram_wr_req), 64'd1);
                chk("cont_data", 64'(sdram_wr_data), 64'h100 + 64'(i - 1));
            end
            tick();
        end
        set_wr(1'b0, 32'h0, 32'h0);
        chk("cont_req_last", 64'(sdram_wr_req), 64'd1);
        chk("cont_data_last", 64'(sdram_wr_data), 64'h107);
        tick();
        sdram_wr_ack = 1'b0;
        chk("cont_idle", 64'(sdram_wr_req), 64'd0);
        chk("cont_pend", 64'(wr_pending), 64'd0);

        // Reset mid-drain
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, 32'h300 + 32'(i), 32'h31 + 32'(i));
            tick();
        end
        set_wr(1'b0, 32'h0, 32'h0);
        chk("mid_req", 64'(sdram_wr_req), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", 64'(sdram_wr_req), 64'd0);
        chk("mid_rst_pend", 64'(wr_pending), 64'd0);
        sdram_wr_ack = 1'b1;
        tick();
        chk("post_rst_req", 64'(sdram_wr_req), 64'd0);
        tick();
        chk("post_rst_pend", 64'(wr_pending), 64'd0);
        sdram_wr_ack = 1'b0;
        set_wr(1'b1, 32'h0000_0404, 32'h77);
        tick();
        set_wr(1'b0, 32'h0, 32'h0);
        chk("post_rst_head", 64'(sdram_wr_data), 64'h77);
        chk("post_rst_addr", 64'(sdram_wr_addr), 64'h404);
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        chk("post_rst_idle", 64'(wr_pending), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_write_ctrl.md
# mem_write_ctrl

Write-path controller between the CPU data-memory write port and the two write targets, GPIO and SDRAM. Decodes the address MSB and issues GPIO writes immediately as a registered one-cycle strobe. Posts SDRAM writes into a small FIFO and drains them to the SDRAM controller over a req/ack handshake. Stalls the CPU only when an SDRAM write arrives while the FIFO is full.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 32, write address width; bit ADDR_WIDTH-1 selects target (1 = GPIO, 0 = SDRAM)
- FIFO_DEPTH, 4, posted SDRAM write entries; power of two, >= 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  CPU write request, valid for one cycle unless stalled
- wr_address  in  ADDR_WIDTH  CPU write address
- wr_data  in  DATA_WIDTH  CPU write data
- wr_stall  out  1  combinational; CPU must hold wr_en/address/data while high
- we_gpio  out  1  registered GPIO write strobe
- wr_data_gpio  out  DATA_WIDTH  registered GPIO write data
- sdram_wr_req  out  1  SDRAM write request
- sdram_wr_addr  out  ADDR_WIDTH  FIFO head address; stable while req high
- sdram_wr_data  out  DATA_WIDTH  FIFO head data; stable while req high
- sdram_wr_ack  in  1  SDRAM controller accepts head when sampled high with req high
- wr_pending  out  1  FIFO non-empty or request outstanding

## Operation
- Target decode: gpio_hit = wr_address[ADDR_WIDTH-1]; sdram_hit = ~gpio_hit.
- wr_stall = wr_en & sdram_hit & fifo_full. No same-cycle bypass: full stalls even if a pop occurs that cycle. GPIO writes never stall.
- GPIO accept (wr_en & gpio_hit): at edge, we_gpio <= 1, wr_data_gpio <= wr_data. Otherwise we_gpio <= 0, wr_data_gpio <= 0.
- SDRAM accept (wr_en & sdram_hit & ~fifo_full): push {wr_address, wr_data} at edge.
- FIFO: read/write pointers of log2(FIFO_DEPTH) bits, wrap modulo depth; count of log2(FIFO_DEPTH)+1 bits. Push and pop in the same cycle leave count unchanged.
- Drain FSM, 2 states:
  - IDLE: sdram_wr_req = 0. If FIFO non-empty at the edge, go to REQ.
  - REQ: sdram_wr_req = 1, addr/data = FIFO head. On ack, pop. If count after pop > 0, stay in REQ with the new head; else go to IDLE.
- ack while not in REQ is ignored.
- Ordering: SDRAM writes retire strictly in acceptance order. A GPIO write may complete before earlier posted SDRAM writes; this is intended.
- wr_pending = (count != 0) | sdram_wr_req.
- sdram_wr_addr/data show the FIFO head combinationally. They are don't-care in IDLE but must not be X after reset; drive 0 when empty.

## Timing
- Reset (edge with rst = 1): we_gpio = 0, wr_data_gpio = 0, sdram_wr_req = 0, FIFO emptied, state IDLE, wr_pending = 0, wr_stall = 0.
- Reset mid-transfer: request drops the cycle after the reset edge; all posted writes are discarded.
- GPIO latency: wr_en at cycle N gives we_gpio high in cycle N+1 for exactly one cycle. Back-to-back GPIO writes give we_gpio high on consecutive cycles.
- SDRAM latency: write accepted at edge N into an empty FIFO in IDLE gives sdram_wr_req high in cycle N+1.
- Throughput: with ack held high, one write retires per cycle; req stays continuously high while entries remain.
- Stall: when full, a stalled write is accepted at the first edge after the count drops below FIFO_DEPTH, i.e. the cycle after an ack pop.
- A write arriving on the same edge as the last pop keeps the FSM in REQ; req does not drop.

## Test plan
- Reset then GPIO write: wr_address = 0x8000_0010, wr_data = 0xDEAD_BEEF -> we_gpio = 1 with wr_data_gpio = 0xDEAD_BEEF in the next cycle only; sdram_wr_req stays 0.
- Single SDRAM write: addr 0x0000_0100, data 0x1234_5678, ack returned 3 cycles after req -> req high from N+1, addr/data stable until ack, then req = 0 and wr_pending = 0.
- Fill and stall: ack held low, 5 SDRAM writes (data 1..5) -> writes 1-4 accepted, wr_stall = 1 on write 5. First ack pops data 1; write 5 is accepted the next cycle. Drain order is 1,2,3,4,5.
- GPIO while full: FIFO full, ack low, GPIO write 0xA5A5_A5A5 -> no stall, we_gpio pulses, FIFO contents unchanged.
- Continuous ack: 8 SDRAM writes on consecutive cycles, ack tied high -> no stalls, req high for 8 consecutive cycles, data in order, then IDLE.
- Reset mid-drain: 3 entries queued, rst asserted during REQ -> req = 0, wr_pending = 0 next cycle; no further acks consumed after rst deasserts.
